nios_cpu_gpio_in: RTL



---
 rtl/nios_cpu_gpio_pkg.sv | 32 +++
 rtl/nios_cpu_gpio_sync.sv | 31 +++
 rtl/nios_cpu_gpio_in.sv | 131 +++++++++++++
 3 files changed

// File: rtl/nios_cpu_gpio_pkg.sv
// Shared constants and helpers for the Nios GPIO input port.
// Register word addresses, edge-type encodings and the edge selector.
package nios_cpu_gpio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Returns the per-bit edge events of the requested type; any unknown
    // encoding falls back to "any edge" so no transition is silently lost.
    function automatic logic [31:0] edge_select(
        input int          etype,
        input logic [31:0] cur,
        input logic [31:0] prev
    );
        logic [31:0] rise;
        logic [31:0] fall;
        rise = cur & ~prev;
        fall = ~cur & prev;
        case (etype)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            default:   return rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/nios_cpu_gpio_sync.sv
// Multi-flop vector synchronizer for asynchronous GPIO input pins.
// Every stage resets to 0 so the port reads 0 until real pin data arrives.
module nios_cpu_gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the pin sample through the synchronizer chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/nios_cpu_gpio_in.sv
// Avalon-MM PIO input port: synchronized pins, edge capture, maskable irq.
// Build option GPIO_IN_BIT_CLEAR_EN: when defined, a write to EDGECAP clears
// only the bits set in writedata; otherwise any EDGECAP write clears all bits.
// A detected edge always beats a same-cycle clear.
module nios_cpu_gpio_in
    import nios_cpu_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]   sync_q;
    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   edgecap_q;
    logic [WIDTH-1:0]   irqmask_q;
    logic [PRIME_W-1:0] prime_q;
    logic               edge_en;
    logic [31:0]        edge_all;
    logic [WIDTH-1:0]   edge_det;
    logic               rd_en;
    logic               wr_en;
    logic [WIDTH-1:0]   clr_mask;
    logic [31:0]        rd_data;
    logic               unused_bits;

    nios_cpu_gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_q)
    );

    assign rd_en = chipselect & write_n;
    assign wr_en = chipselect & ~write_n;

    // One-cycle delayed copy of the synchronized pins for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q;
        end
    end

    // Priming counter: keeps detection off until the synchronizer and
    // prev_q hold real pin data, so pins high at reset never capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_q <= '0;
        end else if (prime_q != PRIME_DONE) begin
            prime_q <= prime_q + 1'b1;
        end
    end

    assign edge_en  = (prime_q == PRIME_DONE);
    assign edge_all = edge_select(EDGE_TYPE, 32'(sync_q), 32'(prev_q));
    assign edge_det = edge_en ? edge_all[WIDTH-1:0] : '0;

    // Bits cleared by this cycle's EDGECAP write (zero when no such write).
    always_comb begin
        clr_mask = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
`ifdef GPIO_IN_BIT_CLEAR_EN
            clr_mask = writedata[WIDTH-1:0];
`else
            clr_mask = '1;
`endif
        end
    end

    // Sticky edge capture; the set term is ORed last so an edge wins a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_q <= '0;
        end else begin
            edgecap_q <= (edgecap_q & ~clr_mask) | edge_det;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
        end else if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_q <= writedata[WIDTH-1:0];
        end
    end

    // Read mux; unused upper bits and the reserved word read as 0.
    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_DATA:    rd_data[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: rd_data[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: rd_data[WIDTH-1:0] = edgecap_q;
            default:      rd_data = '0;
        endcase
    end

    // Registered read data with one cycle of latency; holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_data;
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

    // Bits of the bus and edge word that this port width does not use.
    assign unused_bits = ^{writedata, edge_all};

endmodule
